cascade_counter: RTL and testbench
==================================

CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter register width in bits (1..32).
REQ-002 SHALL provide parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port clr  input  1  synchronous clear request.
REQ-006 SHALL provide port load  input  1  synchronous parallel-load request.
REQ-007 SHALL provide port din  input  WIDTH  parallel-load data.
REQ-008 SHALL provide port cep  input  1  count enable, parallel (local only).
REQ-009 SHALL provide port cet  input  1  count enable, trickle (gates count and rco).
REQ-010 SHALL provide port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 SHALL provide port q  output  WIDTH  registered count value.
REQ-012 SHALL provide port tc  output  1  combinational terminal-count flag.
REQ-013 SHALL provide port rco  output  1  combinational ripple-carry out for cascading.
REQ-014 SHALL provide port wrap  output  1  registered one-cycle wrap-event pulse.

Function
REQ-015 SHALL apply per-edge priority: clr > load > count (cep & cet) > hold.
REQ-016 SHALL, on clr=1, set q=0 and wrap=0 at next edge, ignoring all other inputs.
REQ-017 SHALL, on load=1 (clr=0), set q=din if din<=MODULUS-1, else q=MODULUS-1 (saturate); wrap=0.
REQ-018 SHALL, on count with up=1, set q=q+1, except q=MODULUS-1 -> q=0 with wrap=1.
REQ-019 SHALL, on count with up=0, set q=q-1, except q=0 -> q=MODULUS-1 with wrap=1.
REQ-020 SHALL hold q when cep=0 or cet=0 (and no clr/load); wrap=0 on every non-wrapping edge.
REQ-021 SHALL drive tc = (up ? q==MODULUS-1 : q==0), reflecting current up with zero latency.
REQ-022 SHALL drive rco = tc & cet, independent of cep, so rco of stage N drives cet of stage N+1.
REQ-023 SHALL have count latency of one cycle: q changes on the edge at which enable is sampled.
REQ-024 SHALL never hold a q value >= MODULUS in any cycle, including after reset, load or direction change.
REQ-025 SHALL treat a direction change as taking effect on the same edge as the count it accompanies; no extra state.
REQ-026 SHALL, when WIDTH=1 and MODULUS=2, behave as a toggle flop with tc=q (up) or tc=~q (down).

Reset
REQ-027 SHALL, on rst_n=0, immediately (asynchronously) set q=0 and wrap=0 regardless of clk.
REQ-028 SHALL keep q=0, wrap=0 while rst_n=0; first update occurs on first rising edge after rst_n deasserts.
REQ-029 SHALL abort any count in progress on reset mid-operation; no wrap pulse survives reset.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-030 SHALL verify up count: reset, cep=cet=up=1 for 12 edges -> q 1..9,0,1,2; wrap=1 only in cycle after 9->0; tc=1 while q=9.
REQ-031 SHALL verify down wrap and load saturation: load din=15 -> q=9; up=0, count 10 edges -> q 8..0,9; wrap pulse after 0->9; tc=1 at q=0.
REQ-032 SHALL verify priority: clr=load=cep=cet=1, din=5, q=7 -> q=0; next clr=0,load=1 -> q=5.
REQ-033 SHALL verify enables: q=9, up=1, cep=0, cet=1 -> q holds 9, tc=1, rco=1; cet=0 -> rco=0, q holds.
REQ-034 SHALL verify cascade: two instances, rco(low)->cet(high), cep=1 both; 100 edges from 0 -> combined {high,low}=0,0 with high wrap pulse once.
REQ-035 SHALL verify async reset mid-count: q=6 counting, rst_n low between edges -> q=0, wrap=0 immediately, before next clk edge.

Source files
------------

// File: rtl/cascade_counter.sv
// Cascadable modulo-MODULUS up/down counter with synchronous clear, saturating
// parallel load, 74x163-style cep/cet enables, terminal count and wrap pulse.
module cascade_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             cep,
  input  logic             cet,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             rco,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bottom;

  assign at_top    = (count_q == MAX_VAL);
  assign at_bottom = (count_q == '0);

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (cep && cet) begin
      if (up) begin
        if (at_top) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count follows the live direction input, so it flips with up immediately.
  assign q    = count_q;
  assign tc   = up ? at_top : at_bottom;
  assign rco  = tc & cet;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: decade counter against an arithmetic
// model, a two-stage decade cascade and a 1-bit toggle configuration.
module tb_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, cep, cet, up;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc, rco, wrap;

  logic       c_en;
  logic [3:0] c_lo_q, c_hi_q;
  logic       c_lo_tc, c_lo_rco, c_lo_wrap, c_hi_tc, c_hi_rco, c_hi_wrap;

  logic       t_en, t_up;
  logic [0:0] t_q;
  logic       t_tc, t_rco, t_wrap;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cascade_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din),
    .cep(cep), .cet(cet), .up(up), .q(q), .tc(tc), .rco(rco), .wrap(wrap)
  );

  cascade_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .din(4'd0),
    .cep(c_en), .cet(1'b1), .up(1'b1), .q(c_lo_q), .tc(c_lo_tc),
    .rco(c_lo_rco), .wrap(c_lo_wrap)
  );

  cascade_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .din(4'd0),
    .cep(c_en), .cet(c_lo_rco), .up(1'b1), .q(c_hi_q), .tc(c_hi_tc),
    .rco(c_hi_rco), .wrap(c_hi_wrap)
  );

  cascade_counter #(.WIDTH(1), .MODULUS(2)) u_tog (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .din(1'b0),
    .cep(t_en), .cet(1'b1), .up(t_up), .q(t_q), .tc(t_tc),
    .rco(t_rco), .wrap(t_wrap)
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model of the decade counter: integer count modulo 10.
  int m_q = 0;
  int m_wrap = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= 0;
      m_wrap <= 0;
    end else if (clr) begin
      m_q    <= 0;
      m_wrap <= 0;
    end else if (load) begin
      m_q    <= (int'(din) > 9) ? 9 : int'(din);
      m_wrap <= 0;
    end else if (cep && cet) begin
      m_q    <= up ? (m_q + 1) % 10 : (m_q + 9) % 10;
      m_wrap <= up ? int'(m_q == 9) : int'(m_q == 0);
    end else begin
      m_wrap <= 0;
    end
  end

  always @(negedge clk) begin
    automatic int m_tc = up ? int'(m_q == 9) : int'(m_q == 0);
    check("model_q", q, m_q);
    check("model_wrap", wrap, m_wrap);
    check("model_tc", tc, m_tc);
    check("model_rco", rco, m_tc & int'(cet));
    check("q_in_range", int'(q < 4'd10), 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_seq[10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    int hi_wraps;

    rst_n = 1'b0;
    clr = 1'b0; load = 1'b0; din = 4'd0; cep = 1'b0; cet = 1'b0; up = 1'b1;
    c_en = 1'b0; t_en = 1'b0; t_up = 1'b1;

    tick();
    check("reset_q", q, 0);
    check("reset_wrap", wrap, 0);
    tick();
    check("reset_hold_q", q, 0);

    // Up count through the 9 -> 0 wrap.
    cep = 1'b1; cet = 1'b1; up = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_q", q, up_seq[i]);
      check("up_wrap", wrap, int'(i == 9));
      check("up_tc", tc, int'(up_seq[i] == 9));
    end

    // Saturating load, then down count through the 0 -> 9 wrap.
    load = 1'b1; din = 4'd15;
    tick();
    check("load_sat_q", q, 9);
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("down_q", q, dn_seq[i]);
      check("down_wrap", wrap, int'(i == 9));
      check("down_tc", tc, int'(dn_seq[i] == 0));
    end

    // Priority: clear beats load beats count.
    load = 1'b1; din = 4'd7; cep = 1'b0;
    tick();
    check("load7_q", q, 7);
    clr = 1'b1; load = 1'b1; cep = 1'b1; cet = 1'b1; din = 4'd5;
    tick();
    check("clr_prio_q", q, 0);
    check("clr_prio_wrap", wrap, 0);
    clr = 1'b0;
    tick();
    check("load_prio_q", q, 5);

    // Enables: cep only gates the count, cet also gates rco.
    din = 4'd9; cep = 1'b0;
    tick();
    load = 1'b0; up = 1'b1; cet = 1'b1;
    #1;
    check("en_tc", tc, 1);
    check("en_rco", rco, 1);
    tick();
    check("cep0_hold_q", q, 9);
    cet = 1'b0;
    #1;
    check("cet0_rco", rco, 0);
    check("cet0_tc", tc, 1);
    tick();
    check("cet0_hold_q", q, 9);

    // A pending wrap pulse is killed by asynchronous reset.
    cep = 1'b1; cet = 1'b1;
    tick();
    check("pre_rst_wrap", wrap, 1);
    rst_n = 1'b0;
    #1;
    check("rst_kill_wrap", wrap, 0);
    check("rst_kill_q", q, 0);
    tick();
    rst_n = 1'b1;

    // Asynchronous reset between edges while counting at 6.
    load = 1'b1; din = 4'd5;
    tick();
    load = 1'b0;
    tick();
    check("pre_rst_q6", q, 6);
    rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_wrap", wrap, 0);
    tick();
    check("rst_low_q", q, 0);
    cep = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_hold_q", q, 0);

    // Two-stage decade cascade: 100 edges return to 00 with one high-stage wrap.
    hi_wraps = 0;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      check("cascade_val", int'(c_hi_q) * 10 + int'(c_lo_q), i % 100);
      hi_wraps += int'(c_hi_wrap);
    end
    c_en = 1'b0;
    check("cascade_lo_end", c_lo_q, 0);
    check("cascade_hi_end", c_hi_q, 0);
    check("cascade_hi_wraps", hi_wraps, 1);

    // WIDTH=1 behaves as a toggle flop.
    t_en = 1'b1; t_up = 1'b1;
    tick();
    check("tog_q1", t_q, 1);
    check("tog_tc_up", t_tc, 1);
    check("tog_wrap0", t_wrap, 0);
    tick();
    check("tog_q0", t_q, 0);
    check("tog_wrap_up", t_wrap, 1);
    t_up = 1'b0;
    #1;
    check("tog_tc_down", t_tc, 1);
    tick();
    check("tog_q_down", t_q, 1);
    check("tog_wrap_down", t_wrap, 1);
    check("tog_tc_down1", t_tc, 0);
    t_en = 1'b0;

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
